radius_envelope: RTL
====================

Name: radius_envelope

Overview:
- Upstream feeder for the ring/bar plotter: converts note trigger events into two slowly varying radius values (radius1, radius2) that the plotter consumes.
- Channel 0 (piano key events) drives radius1; channel 1 (music-box note events) drives radius2.
- Each channel runs an attack/hold/decay envelope on a prescaled tick.
- Outputs change only on a frame-sync strobe, so radii stay stable for a whole drawn frame.

Parameters:
- TICK_DIV, 20'd833333, clocks per envelope tick (60 Hz at 50 MHz); must be >= 2.
- ATK_STEP, 7'd8, radius increment per tick during ATTACK.
- HOLD_TICKS, 8'd6, ticks spent at peak.
- DECAY_DIV, 8'd2, ticks per 1-unit radius decrement during DECAY; must be >= 1.
- RMIN, 7'd4, resting radius.
- PEAK_STEP, 7'd7, peak radius increment per velocity step.
- RMAX, 7'd59, radius ceiling, keeping bars on screen (2*59 < 120).

Ports:
- clock  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- trig  in  2  per-channel note strobe, one clock wide; bit0 = piano, bit1 = music box
- vel0  in  3  channel 0 velocity, sampled when trig[0]=1
- vel1  in  3  channel 1 velocity, sampled when trig[1]=1
- frame_sync  in  1  one-clock strobe at frame start; latches outputs
- radius1  out  7  channel 0 radius, frame-stable
- radius2  out  7  channel 1 radius, frame-stable
- active  out  2  per-channel "state != IDLE", not frame-synced

Behaviour:
- Reset (resetn low, asynchronous):
  - tick_cnt = 0; both channels IDLE with level = RMIN, peak = RMIN, hold_cnt = 0, dec_cnt = 0.
  - radius1 = radius2 = RMIN; active = 2'b00.
- Tick generation:
  - tick_cnt counts 0..TICK_DIV-1 and wraps.
  - tick = 1 for the single clock where tick_cnt == TICK_DIV-1; both channels share it.
- Channel trigger (any state):
  - Latches peak = min(RMIN + (vel+1)*PEAK_STEP, RMAX), computed 8-bit before the clamp.
  - Next state ATTACK; level is unchanged (retrigger continues from the current level).
  - Trigger takes priority over a same-cycle tick: that tick is ignored for that channel.
- ATTACK, on tick:
  - level <= (level + ATK_STEP >= peak) ? peak : level + ATK_STEP.
  - When peak is reached, go to HOLD in the same update with hold_cnt = 0.
  - If level is already above peak (retrigger with lower velocity), level snaps to peak and the state goes to HOLD.
- HOLD, on tick: hold_cnt increments. When hold_cnt == HOLD_TICKS-1, go to DECAY with dec_cnt = 0. If HOLD_TICKS == 0, go to DECAY on the first tick.
- DECAY, on tick:
  - dec_cnt increments. When dec_cnt == DECAY_DIV-1, dec_cnt returns to 0 and level decrements by 1.
  - When the decremented level equals RMIN, go to IDLE.
  - level never goes below RMIN.
- IDLE: level holds at RMIN; ticks are ignored.
- Output update:
  - On frame_sync, radius1 <= level0 and radius2 <= level1, both registered.
  - A frame_sync coinciding with trig or tick latches the pre-update level values.
- Timing:
  - active[i] is a decode of the registered state and rises one clock after trig[i].
  - Latency from a tick-driven level change to the output is up to one frame.
- Arithmetic: all radius math uses 8-bit intermediates, so no 7-bit wrap is possible.

Optional Feature:
- Macro: RADIUS_ORDER_EN.
- Defined: output latch applies radius2 <= min(level1, level0), guaranteeing radius2 <= radius1. The inner white disc then never exceeds the coloured ring. radius1 is unaffected.
- Undefined: both radii latch independently, as above.

Decomposition:
- Package radius_env_pkg holds:
  - the state encoding: IDLE = 2'd0, ATTACK = 2'd1, HOLD = 2'd2, DECAY = 2'd3;
  - RAD_W = 7;
  - the peak-computation function.
- Sub-module env_channel holds one channel's state machine, level, peak and counters; it is instantiated twice.
- The top level holds the tick prescaler, the frame-sync output registers and the optional ordering clamp.

Test Plan:
Bench parameters: TICK_DIV=4, ATK_STEP=8, HOLD_TICKS=2, DECAY_DIV=1, RMIN=4, PEAK_STEP=7, RMAX=59; frame_sync pulsed every clock unless noted.
- Reset values: assert resetn=0 mid-ATTACK -> radius1 = radius2 = 4 and active = 0 immediately, without waiting for a clock edge.
- Single note: trig[0] with vel0=3 -> peak 32.
  - radius1 sequence per tick: 12, 20, 28, 32.
  - Held at 32 for 2 ticks, then decreases by 1 per tick to 4.
  - active[0] falls when the level reaches 4 (total 4+2+28 ticks).
- Clamp: vel1=7 -> peak min(60, 59) = 59; radius2 stops at 59.
- Retrigger: during HOLD at 32, trig[0] with vel0=0 -> peak 11; next tick radius1 = 11, HOLD, then decay to 4.
- Trigger/tick collision: trig[0] on the tick cycle -> no level change that tick; first increment at the following tick.
- Frame stability: frame_sync every 20 clocks -> radius1 changes only on the clock after a frame_sync.
  - With RADIUS_ORDER_EN: radius1 = 12 and level1 = 32 -> radius2 = 12.

Source files
------------

// File: rtl/radius_env_pkg.sv
// Shared types and helpers for the radius envelope generator: state encoding,
// radius width and the velocity-to-peak mapping.
package radius_env_pkg;

  localparam int RAD_W = 7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ATTACK = 2'd1,
    HOLD   = 2'd2,
    DECAY  = 2'd3
  } env_state_t;

  // Peak radius for a velocity, evaluated 8 bits wide and then clamped to the ceiling.
  function automatic logic [RAD_W-1:0] calc_peak(
    input logic [2:0]       vel,
    input logic [RAD_W-1:0] rmin,
    input logic [RAD_W-1:0] step,
    input logic [RAD_W-1:0] rmax
  );
    logic [7:0] p;
    p = {1'b0, rmin} + ({5'd0, vel} + 8'd1) * {1'b0, step};
    calc_peak = (p > {1'b0, rmax}) ? rmax : p[RAD_W-1:0];
  endfunction

endpackage

// File: rtl/env_channel.sv
// One attack/hold/decay envelope channel advancing on a shared tick; a trigger
// restarts the attack from the current level and overrides a same-cycle tick.
module env_channel
  import radius_env_pkg::*;
#(
  parameter logic [RAD_W-1:0] ATK_STEP   = 7'd8,
  parameter logic [7:0]       HOLD_TICKS = 8'd6,
  parameter logic [7:0]       DECAY_DIV  = 8'd2,
  parameter logic [RAD_W-1:0] RMIN       = 7'd4,
  parameter logic [RAD_W-1:0] PEAK_STEP  = 7'd7,
  parameter logic [RAD_W-1:0] RMAX       = 7'd59
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             trig,
  input  logic             tick,
  input  logic [2:0]       vel,
  output logic [RAD_W-1:0] level,
  output logic             active
);

  env_state_t       state;
  logic [RAD_W-1:0] peak;
  logic [7:0]       hold_cnt;
  logic [7:0]       dec_cnt;
  logic [7:0]       atk_sum;
  logic [7:0]       dec_lvl;

  // NOTE: every signal assigned in always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
    atk_sum = {1'b0, level} + {1'b0, ATK_STEP};
    dec_lvl = {1'b0, level} - 8'd1;
  end

  assign active = (state != IDLE);

  // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      level    <= RMIN;
      peak     <= RMIN;
      hold_cnt <= '0;
      dec_cnt  <= '0;
    end else if (trig) begin
      peak  <= calc_peak(vel, RMIN, PEAK_STEP, RMAX);
      state <= ATTACK;
    end else if (tick) begin
      case (state)
        ATTACK: begin
          // Also covers a retrigger that left level above the new, lower peak.
          if (atk_sum >= {1'b0, peak}) begin
            level    <= peak;
            state    <= HOLD;
            hold_cnt <= '0;
          end else begin
            level <= atk_sum[RAD_W-1:0];
          end
        end
        HOLD: begin
          if ((HOLD_TICKS == 8'd0) || (hold_cnt == HOLD_TICKS - 8'd1)) begin
            state   <= DECAY;
            dec_cnt <= '0;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        DECAY: begin
          if (dec_cnt == DECAY_DIV - 8'd1) begin
            dec_cnt <= '0;
            if (dec_lvl <= {1'b0, RMIN}) begin
              level <= RMIN;
              state <= IDLE;
            end else begin
              level <= dec_lvl[RAD_W-1:0];
            end
          end else begin
            dec_cnt <= dec_cnt + 8'd1;
          end
        end
        default: level <= RMIN;
      endcase
    end
  end

endmodule

// File: rtl/radius_envelope.sv
// Two-channel radius envelope feeder with tick prescaler and frame-synced outputs.
// Define RADIUS_ORDER_EN to clamp radius2 to at most radius1's source level.
module radius_envelope
  import radius_env_pkg::*;
#(
  parameter logic [19:0]      TICK_DIV   = 20'd833333,
  parameter logic [RAD_W-1:0] ATK_STEP   = 7'd8,
  parameter logic [7:0]       HOLD_TICKS = 8'd6,
  parameter logic [7:0]       DECAY_DIV  = 8'd2,
  parameter logic [RAD_W-1:0] RMIN       = 7'd4,
  parameter logic [RAD_W-1:0] PEAK_STEP  = 7'd7,
  parameter logic [RAD_W-1:0] RMAX       = 7'd59
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [1:0]       trig,
  input  logic [2:0]       vel0,
  input  logic [2:0]       vel1,
  input  logic             frame_sync,
  output logic [RAD_W-1:0] radius1,
  output logic [RAD_W-1:0] radius2,
  output logic [1:0]       active
);

  logic [19:0]      tick_cnt;
  logic             tick;
  logic [RAD_W-1:0] level0;
  logic [RAD_W-1:0] level1;
  logic [RAD_W-1:0] radius2_next;

  assign tick = (tick_cnt == TICK_DIV - 20'd1);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)   tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + 20'd1;
  end

  env_channel #(
    .ATK_STEP(ATK_STEP), .HOLD_TICKS(HOLD_TICKS), .DECAY_DIV(DECAY_DIV),
    .RMIN(RMIN), .PEAK_STEP(PEAK_STEP), .RMAX(RMAX)
  ) u_ch0 (
    .clock(clock), .resetn(resetn), .trig(trig[0]), .tick(tick),
    .vel(vel0), .level(level0), .active(active[0])
  );

  env_channel #(
    .ATK_STEP(ATK_STEP), .HOLD_TICKS(HOLD_TICKS), .DECAY_DIV(DECAY_DIV),
    .RMIN(RMIN), .PEAK_STEP(PEAK_STEP), .RMAX(RMAX)
  ) u_ch1 (
    .clock(clock), .resetn(resetn), .trig(trig[1]), .tick(tick),
    .vel(vel1), .level(level1), .active(active[1])
  );

`ifdef RADIUS_ORDER_EN
  // Keeps the inner disc inside the coloured ring.
  assign radius2_next = (level1 < level0) ? level1 : level0;
`else
  assign radius2_next = level1;
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      radius1 <= RMIN;
      radius2 <= RMIN;
    end else if (frame_sync) begin
      radius1 <= level0;
      radius2 <= radius2_next;
    end
  end

endmodule
